// File: rtl/reservoir_input_masker.sv
// Feeds one input sample into the reservoir as VIRTUAL_NODES masked updates,
// handshaking each node with res_en / res_valid.
module reservoir_input_masker #(
  parameter int VIRTUAL_NODES = 10,
  parameter int DATA_WIDTH    = 32,
  parameter int SAMPLE_WIDTH  = 16,
  parameter int MASK_WIDTH    = 16,
  localparam int AW = (VIRTUAL_NODES > 1) ? $clog2(VIRTUAL_NODES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [SAMPLE_WIDTH-1:0] s_data,
  input  logic                    mask_we,
  input  logic [AW-1:0]           mask_addr,
  input  logic [MASK_WIDTH-1:0]   mask_wdata,
  output logic                    mask_wr_err,
  output logic [DATA_WIDTH-1:0]   res_din,
  output logic                    res_en,
  input  logic                    res_valid,
  output logic [AW-1:0]           node_idx,
  output logic                    busy,
  output logic                    sample_done
);

  localparam int SHIFT = DATA_WIDTH - SAMPLE_WIDTH - MASK_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MULT,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  state_t                          state_q, state_d;
  logic [AW-1:0]                   k_q, k_d;
  logic [SAMPLE_WIDTH-1:0]         s_data_q, s_data_d;
  logic [DATA_WIDTH-1:0]           res_din_q, res_din_d;
  logic [MASK_WIDTH-1:0]           mask_q [VIRTUAL_NODES];
  logic [MASK_WIDTH-1:0]           mask_d [VIRTUAL_NODES];
  logic                            mask_wr_err_q, mask_wr_err_d;

  logic                            last_node;
  logic                            addr_ok;
  logic                            wr_ok;
  logic [MASK_WIDTH-1:0]           mask_sel;
  logic [SAMPLE_WIDTH+MASK_WIDTH-1:0] product;

  // State register and all datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      k_q           <= '0;
      s_data_q      <= '0;
      res_din_q     <= '0;
      mask_wr_err_q <= 1'b0;
      for (int unsigned i = 0; i < VIRTUAL_NODES; i++) begin
        mask_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      s_data_q      <= s_data_d;
      res_din_q     <= res_din_d;
      mask_wr_err_q <= mask_wr_err_d;
      mask_q        <= mask_d;
    end
  end

  assign last_node = (k_q == AW'(VIRTUAL_NODES - 1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (s_valid) state_d = ST_MULT;
      ST_MULT:  state_d = ST_ISSUE;
      ST_ISSUE: if (res_valid) state_d = ST_WAIT;
      ST_WAIT:  if (res_valid) state_d = last_node ? ST_IDLE : ST_MULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath: sample capture, node counter, masked product, mask table
  always_comb begin
    k_d       = k_q;
    s_data_d  = s_data_q;
    res_din_d = res_din_q;

    mask_sel = '0;
    for (int unsigned i = 0; i < VIRTUAL_NODES; i++) begin
      if (k_q == AW'(i)) mask_sel = mask_q[i];
    end
    product = s_data_q * mask_sel;

    if (state_q == ST_IDLE && s_valid) begin
      s_data_d = s_data;
      k_d      = '0;
    end
    if (state_q == ST_MULT) begin
      res_din_d = DATA_WIDTH'(product) << SHIFT;
    end
    if (state_q == ST_WAIT && res_valid && !last_node) begin
      k_d = k_q + 1'b1;
    end

    // Writes land at the accept edge, so a same-cycle sample sees them in MULT
    addr_ok = (32'(mask_addr) < 32'(VIRTUAL_NODES));
    wr_ok   = mask_we && (state_q == ST_IDLE) && addr_ok;
    for (int unsigned i = 0; i < VIRTUAL_NODES; i++) begin
      mask_d[i] = mask_q[i];
      if (wr_ok && mask_addr == AW'(i)) mask_d[i] = mask_wdata;
    end
    mask_wr_err_d = mask_we && !wr_ok;
  end

  // Output logic
  always_comb begin
    s_ready     = (state_q == ST_IDLE);
    busy        = (state_q != ST_IDLE);
    res_en      = (state_q == ST_ISSUE) && res_valid;
    sample_done = (state_q == ST_WAIT) && res_valid && last_node;
  end

  assign res_din     = res_din_q;
  assign node_idx    = k_q;
  assign mask_wr_err = mask_wr_err_q;

endmodule

// File: tb/tb_reservoir_input_masker.sv
// Scoreboard bench: expected per-node reservoir updates are queued at sample
// acceptance and checked by a monitor on every res_en.
module tb_reservoir_input_masker;

  localparam int VN = 10;
  localparam int DW = 32;
  localparam int SW = 16;
  localparam int MW = 16;
  localparam int AW = 4;
  localparam int SH = DW - SW - MW;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [SW-1:0] s_data;
  logic          mask_we;
  logic [AW-1:0] mask_addr;
  logic [MW-1:0] mask_wdata;
  logic          mask_wr_err;
  logic [DW-1:0] res_din;
  logic          res_en;
  logic          res_valid;
  logic [AW-1:0] node_idx;
  logic          busy;
  logic          sample_done;

  reservoir_input_masker #(
    .VIRTUAL_NODES(VN),
    .DATA_WIDTH   (DW),
    .SAMPLE_WIDTH (SW),
    .MASK_WIDTH   (MW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .mask_we    (mask_we),
    .mask_addr  (mask_addr),
    .mask_wdata (mask_wdata),
    .mask_wr_err(mask_wr_err),
    .res_din    (res_din),
    .res_en     (res_en),
    .res_valid  (res_valid),
    .node_idx   (node_idx),
    .busy       (busy),
    .sample_done(sample_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            node;
    bit            last;
  } exp_t;

  exp_t          exp_q[$];
  logic [MW-1:0] shadow [VN];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            res_cnt  = 0;
  int            conv_max = 3;
  bit            hold_dir = 1'b0;
  bit            hold_rand_en = 1'b0;
  bit            hold_rand = 1'b0;
  bit            done_expected = 1'b0;
  int            en0_cyc = -1;
  int            done_cyc = -1;
  int            en_count = 0;
  int            done_count = 0;

  assign res_valid = (res_cnt == 0) && !hold_dir && !hold_rand;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_val(input logic [SW-1:0] s, input logic [MW-1:0] m);
    longint unsigned p;
    p = longint'(s) * longint'(m);
    return DW'(p << SH);
  endfunction

  always @(posedge clk) cyc++;

  // Reservoir: busy for 1..conv_max cycles after each res_en
  always begin : reservoir
    bit en_seen;
    @(negedge clk);
    en_seen = res_en;
    @(posedge clk);
    #1;
    if (rst) res_cnt = 0;
    else if (en_seen) res_cnt = $urandom_range(1, conv_max);
    else if (res_cnt > 0) res_cnt--;
    hold_rand = hold_rand_en && ($urandom_range(0, 3) == 0);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (res_en) begin
        en_count++;
        check("res_en_while_reservoir_busy", res_valid, 1'b1);
        if (exp_q.size() == 0) begin
          check("res_en_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("res_din", res_din, e.data);
          check("node_idx", node_idx, e.node);
          if (e.node == 0) en0_cyc = cyc;
          if (e.last) done_expected = 1'b1;
        end
      end
      if (sample_done) begin
        done_count++;
        check("sample_done_timing", done_expected, 1'b1);
        done_expected = 1'b0;
        done_cyc = cyc;
      end
    end
  end

  task automatic push_sample(input logic [SW-1:0] s);
    for (int k = 0; k < VN; k++) begin
      exp_t e;
      e.data = model_val(s, shadow[k]);
      e.node = k;
      e.last = (k == VN - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_accept(output int acc_cyc);
    acc_cyc = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (s_ready) begin
        acc_cyc = cyc;
        return;
      end
    end
    check("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_sample(input logic [SW-1:0] s, output int acc_cyc);
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data  = s;
    wait_accept(acc_cyc);
    if (acc_cyc >= 0) push_sample(s);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit finished;
    finished = 1'b0;
    for (int i = 0; i < 3000 && !finished; i++) begin
      @(negedge clk);
      if (!busy) finished = 1'b1;
    end
    check("sample_finish_timeout", finished, 1'b1);
    check("queue_drained", exp_q.size(), 0);
    check("done_seen", done_expected, 1'b0);
  endtask

  task automatic write_mask(input logic [AW-1:0] a, input logic [MW-1:0] d, input bit expect_err);
    @(posedge clk); #1;
    mask_we    = 1'b1;
    mask_addr  = a;
    mask_wdata = d;
    @(posedge clk); #1;
    mask_we = 1'b0;
    if (!expect_err) shadow[a] = d;
    @(negedge clk);
    check("mask_wr_err", mask_wr_err, expect_err);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int acc, acc2, en_before, done_before;
    bit stall_no_en, stall_din_ok, found;
    logic [DW-1:0] stall_exp;
    logic [SW-1:0] s;

    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    mask_we = 1'b0; mask_addr = '0; mask_wdata = '0;
    for (int i = 0; i < VN; i++) shadow[i] = '0;

    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_res_en", res_en, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sample_done", sample_done, 1'b0);
    check("rst_mask_wr_err", mask_wr_err, 1'b0);
    check("rst_res_din", res_din, 0);
    check("rst_node_idx", node_idx, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single sample, half-scale mask on node 0, latency check
    write_mask(0, 16'h8000, 1'b0);
    send_sample(16'h1234, acc);
    wait_done();
    check("first_en_latency", en0_cyc - acc, 2);

    // Ramp masks, full-scale sample
    for (int k = 0; k < VN; k++) write_mask(AW'(k), MW'(k * 32'h1000), 1'b0);
    en_before = en_count; done_before = done_count;
    send_sample(16'hFFFF, acc);
    wait_done();
    check("ramp_en_pulses", en_count - en_before, VN);
    check("ramp_done_pulses", done_count - done_before, 1);

    // Reservoir busy for 20 cycles while in ISSUE
    write_mask(0, 16'h7777, 1'b0);
    hold_dir = 1'b1;
    send_sample(16'h00AB, acc);
    stall_exp = model_val(16'h00AB, 16'h7777);
    @(posedge clk);
    stall_no_en = 1'b1; stall_din_ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (res_en) stall_no_en = 1'b0;
      if (res_din !== stall_exp) stall_din_ok = 1'b0;
    end
    check("stall_no_res_en", stall_no_en, 1'b1);
    check("stall_res_din_stable", stall_din_ok, 1'b1);
    @(posedge clk); #1;
    hold_dir = 1'b0;
    @(negedge clk);
    check("res_en_on_release", res_en, 1'b1);
    wait_done();

    // Rejected writes: while busy, and out of range while idle
    send_sample(16'h4321, acc);
    write_mask(2, 16'hDEAD, 1'b1);
    wait_done();
    write_mask(AW'(VN), 16'hBEEF, 1'b1);
    send_sample(16'h0101, acc);
    wait_done();

    // Mask write and sample in the same idle cycle
    @(posedge clk); #1;
    mask_we = 1'b1; mask_addr = 3; mask_wdata = 16'hA5A5;
    s_valid = 1'b1; s_data = 16'h3C3C;
    shadow[3] = 16'hA5A5;
    wait_accept(acc);
    if (acc >= 0) push_sample(16'h3C3C);
    @(posedge clk); #1;
    mask_we = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    check("same_cycle_wr_err", mask_wr_err, 1'b0);
    wait_done();

    // Reset during WAIT of node 4
    conv_max = 6;
    send_sample(16'h2222, acc);
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (res_en && node_idx == 4) found = 1'b1;
    end
    check("reach_node4", found, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_res_en", res_en, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_s_ready", s_ready, 1'b1);
    check("midrst_node_idx", node_idx, 0);
    exp_q.delete();
    done_expected = 1'b0;
    for (int i = 0; i < VN; i++) shadow[i] = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    conv_max = 3;
    send_sample(16'h5555, acc);
    wait_done();

    // Back-to-back samples with s_valid held high
    for (int k = 0; k < VN; k++) write_mask(AW'(k), MW'($urandom), 1'b0);
    @(posedge clk); #1;
    s_valid = 1'b1; s_data = 16'h1111;
    wait_accept(acc);
    if (acc >= 0) push_sample(16'h1111);
    @(posedge clk); #1;
    s_data = 16'hEEEE;
    wait_accept(acc2);
    if (acc2 >= 0) push_sample(16'hEEEE);
    check("b2b_accept_after_done", acc2, done_cyc + 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    wait_done();

    // Randomized phase with reservoir stalls
    hold_rand_en = 1'b1;
    for (int it = 0; it < 15; it++) begin
      int nw;
      logic [AW-1:0] a;
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        a = AW'($urandom_range(0, VN));
        write_mask(a, MW'($urandom), (32'(a) >= VN));
      end
      s = SW'($urandom);
      send_sample(s, acc);
      if ($urandom_range(0, 1) == 1) write_mask(AW'($urandom_range(0, VN - 1)), MW'($urandom), 1'b1);
      wait_done();
    end
    hold_rand_en = 1'b0;

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
